// File: rtl/vip_bit_morph_3x3_pkg.sv
// Purpose : shared types and helpers for the 3x3 binary morphology path.
// Latency : n/a (package).
// Backpressure : n/a; the video path has none, pixels advance on clken only.
package vip_morph_pkg;

    typedef enum logic {
        MODE_DILATE = 1'b0,
        MODE_ERODE  = 1'b1
    } morph_mode_e;

    // Depth of the control delay line: window register, stage 1, stage 2.
    localparam int LAT = 3;

    // Neutral element of the reduction: 0 for OR (dilate), 1 for AND (erode).
    // Feeding it in for missing neighbours keeps frame edges from growing or shrinking.
    function automatic logic pad_bit(input morph_mode_e m);
        return (m == MODE_ERODE);
    endfunction

    function automatic logic reduce3(input morph_mode_e m, input logic [2:0] v);
        return (m == MODE_ERODE) ? (&v) : (|v);
    endfunction

endpackage

// File: rtl/vip_bit_morph_3x3_if.sv
// Purpose : 1-bit video stream bundle (vsync/href/clken framing plus pixel).
// Latency : n/a (wires only).
// Backpressure : none; the sink must take every clken pulse.
// Ports   : frame_vsync, frame_href, frame_clken, img_bit; master drives, slave receives.
interface vip_bit_morph_3x3_if;
    logic frame_vsync;
    logic frame_href;
    logic frame_clken;
    logic img_bit;

    modport master (output frame_vsync, frame_href, frame_clken, img_bit);
    modport slave  (input  frame_vsync, frame_href, frame_clken, img_bit);
endinterface

// File: rtl/vip_bit_morph_3x3_window.sv
// Purpose : two line buffers + 3x3 window and centre-pixel coordinate counters.
// Latency : 1 clk from clken to updated window; centre lags the input by IMG_W+1 pixels.
// Backpressure : none; everything advances only on i_clken, idle cycles hold state.
// Ports   : i_vs_rise clears counters; i_clken/i_bit pixel in; o_p11..o_p33 raw window
//           (row 1 = oldest line, column 3 = newest pixel); o_col/o_row centre position;
//           o_win_stb one-cycle strobe after each advance whose centre is a real pixel.
module vip_bit_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vs_rise,
    input  logic          i_clken,
    input  logic          i_bit,
    output logic          o_p11, o_p12, o_p13,
    output logic          o_p21, o_p22, o_p23,
    output logic          o_p31, o_p32, o_p33,
    output logic [CW-1:0] o_col,
    output logic [CW-1:0] o_row,
    output logic          o_win_stb
);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
    // One extra bit so IMG_W+1 fits even when IMG_W = 2^CW - 1.
    localparam logic [CW:0]   PRIME_N = (CW+1)'(IMG_W + 1);

    logic [IMG_W-1:0] r_lb1;   // previous line
    logic [IMG_W-1:0] r_lb2;   // line before that
    logic r_p11, r_p12, r_p13;
    logic r_p21, r_p22, r_p23;
    logic r_p31, r_p32, r_p33;

    logic [CW:0]   r_prime;
    logic          r_win_vld;
    logic          r_win_stb;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_row;
    logic          w_primed;

    // Line buffer and window contents are never reset: stale bits only ever
    // reach out-of-frame neighbour positions, which the top level pads over.
    always_ff @(posedge clk) begin
        if (i_clken) begin
            r_lb1 <= {r_lb1[IMG_W-2:0], i_bit};
            r_lb2 <= {r_lb2[IMG_W-2:0], r_lb1[IMG_W-1]};
            r_p11 <= r_p12;  r_p12 <= r_p13;  r_p13 <= r_lb2[IMG_W-1];
            r_p21 <= r_p22;  r_p22 <= r_p23;  r_p23 <= r_lb1[IMG_W-1];
            r_p31 <= r_p32;  r_p32 <= r_p33;  r_p33 <= i_bit;
        end
    end

    // After IMG_W+1 pixels of a frame the window centre lands on pixel (0,0).
    assign w_primed = (r_prime == PRIME_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime   <= '0;
            r_win_vld <= 1'b0;
            r_win_stb <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
        end else begin
            r_win_stb <= 1'b0;
            if (i_vs_rise) begin
                r_prime   <= '0;
                r_win_vld <= 1'b0;
                r_col     <= '0;
                r_row     <= '0;
            end else if (i_clken) begin
                if (!w_primed) begin
                    r_prime <= r_prime + 1'b1;
                end else begin
                    r_win_stb <= 1'b1;
                    r_win_vld <= 1'b1;
                    // The first primed advance is centre (0,0); step from there on.
                    if (r_win_vld) begin
                        if (r_col == COL_MAX) begin
                            r_col <= '0;
                            // Extra lines stay on the last row rather than starting a phantom frame.
                            if (r_row != ROW_MAX) r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign o_p11 = r_p11;  assign o_p12 = r_p12;  assign o_p13 = r_p13;
    assign o_p21 = r_p21;  assign o_p22 = r_p22;  assign o_p23 = r_p23;
    assign o_p31 = r_p31;  assign o_p32 = r_p32;  assign o_p33 = r_p33;
    assign o_col     = r_col;
    assign o_row     = r_row;
    assign o_win_stb = r_win_stb;

endmodule

// File: rtl/vip_bit_morph_3x3.sv
// Purpose : 3x3 binary dilation/erosion with edge padding and border suppression.
// Latency : 3 clk on vsync/href/clken; pixel result valid with post.frame_clken.
// Backpressure : none; gapped clken is tolerated, stages load only on delayed clken.
// Ports   : clk, rst_n (async low); mode 0 = dilate, 1 = erode, latched on vsync rise;
//           per (slave) input stream; post (master) output stream, img_bit 0 while href low.
module vip_bit_morph_3x3
    import vip_morph_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BORDER = 1,
    parameter int CW     = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mode,
    vip_bit_morph_3x3_if.slave  per,
    vip_bit_morph_3x3_if.master post
);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);

    logic           r_vs_d;
    logic           w_vs_rise;
    morph_mode_e    r_mode_q;
    logic [LAT-1:0] r_vs_dl, r_hr_dl, r_ck_dl;

    logic w_p11, w_p12, w_p13, w_p21, w_p22, w_p23, w_p31, w_p32, w_p33;
    logic [CW-1:0] w_col, w_row;
    logic          w_win_stb;

    logic       w_pad, w_top, w_bot, w_lft, w_rgt;
    logic [8:0] w_q;       // padded window, [2:0] top row .. [8:6] bottom row
    logic       w_edge;

    logic [2:0]  r_s1_rows;
    logic        r_s1_keep;
    morph_mode_e r_s1_mode;
    logic        r_bit;

    assign w_vs_rise = per.frame_vsync & ~r_vs_d;

    // Mode is frozen at the frame boundary so a frame is never processed half-and-half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d   <= 1'b0;
            r_mode_q <= MODE_DILATE;
        end else begin
            r_vs_d <= per.frame_vsync;
            if (w_vs_rise) r_mode_q <= morph_mode_e'(mode);
        end
    end

    // Control delay line runs every clk so framing timing is gap-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_dl <= '0;
            r_hr_dl <= '0;
            r_ck_dl <= '0;
        end else begin
            r_vs_dl <= {r_vs_dl[LAT-2:0], per.frame_vsync};
            r_hr_dl <= {r_hr_dl[LAT-2:0], per.frame_href};
            r_ck_dl <= {r_ck_dl[LAT-2:0], per.frame_clken};
        end
    end

    vip_bit_window_3x3 #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vs_rise (w_vs_rise),
        .i_clken   (per.frame_clken),
        .i_bit     (per.img_bit),
        .o_p11     (w_p11), .o_p12 (w_p12), .o_p13 (w_p13),
        .o_p21     (w_p21), .o_p22 (w_p22), .o_p23 (w_p23),
        .o_p31     (w_p31), .o_p32 (w_p32), .o_p33 (w_p33),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_win_stb (w_win_stb)
    );

    // Replace neighbours that fall outside the frame; this also hides line-buffer
    // contents left over from a previous (possibly short) frame.
    always_comb begin
        w_pad = pad_bit(r_mode_q);
        w_top = (w_row == '0);
        w_bot = (w_row == ROW_MAX);
        w_lft = (w_col == '0);
        w_rgt = (w_col == COL_MAX);
        w_q   = '0;
        w_q[0] = (w_top | w_lft) ? w_pad : w_p11;
        w_q[1] =  w_top          ? w_pad : w_p12;
        w_q[2] = (w_top | w_rgt) ? w_pad : w_p13;
        w_q[3] =  w_lft          ? w_pad : w_p21;
        w_q[4] =  w_p22;
        w_q[5] =  w_rgt          ? w_pad : w_p23;
        w_q[6] = (w_bot | w_lft) ? w_pad : w_p31;
        w_q[7] =  w_bot          ? w_pad : w_p32;
        w_q[8] = (w_bot | w_rgt) ? w_pad : w_p33;
    end

    generate
        if (BORDER > 0) begin : g_border
            localparam logic [CW-1:0] B_LO = CW'(BORDER);
            localparam logic [CW-1:0] C_HI = CW'(IMG_W - BORDER);
            localparam logic [CW-1:0] R_HI = CW'(IMG_H - BORDER);
            assign w_edge = (w_col < B_LO) | (w_col >= C_HI) |
                            (w_row < B_LO) | (w_row >= R_HI);
        end else begin : g_no_border
            assign w_edge = 1'b0;
        end
    endgenerate

    // Stage 1: per-row reduction. The mode travels with the data so a vsync
    // edge right behind the last pixel cannot change its treatment in stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_rows <= '0;
            r_s1_keep <= 1'b0;
            r_s1_mode <= MODE_DILATE;
        end else if (r_ck_dl[0]) begin
            r_s1_rows[0] <= reduce3(r_mode_q, w_q[2:0]);
            r_s1_rows[1] <= reduce3(r_mode_q, w_q[5:3]);
            r_s1_rows[2] <= reduce3(r_mode_q, w_q[8:6]);
            r_s1_keep    <= w_win_stb & ~w_edge;
            r_s1_mode    <= r_mode_q;
        end
    end

    // Stage 2: combine rows. Cleared in step with href so the output is 0
    // outside lines, otherwise held between clken pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= 1'b0;
        end else if (r_ck_dl[1]) begin
            r_bit <= r_s1_keep & reduce3(r_s1_mode, r_s1_rows);
        end else if (!r_hr_dl[1]) begin
            r_bit <= 1'b0;
        end
    end

    assign post.frame_vsync = r_vs_dl[LAT-1];
    assign post.frame_href  = r_hr_dl[LAT-1];
    assign post.frame_clken = r_ck_dl[LAT-1];
    assign post.img_bit     = r_bit;

endmodule

// File: tb/tb_vip_bit_morph_3x3.sv
// Purpose : directed self-checking bench for vip_bit_morph_3x3 (8x6 frames).
// Latency : expects post_* exactly 3 clk behind per_*; pixel k = window centred on k-9.
// Backpressure : none; stimulus uses gap-1 and gap-3 clken patterns.
module tb_vip_bit_morph_3x3;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    // Rows concatenated {row5 .. row0}; bit c of each byte is column c.
    localparam logic [47:0] IMG_LONE   = {8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
    localparam logic [47:0] IMG_BLOCK  = {8'h00, 8'h3E, 8'h3E, 8'h3E, 8'h3E, 8'h00};
    localparam logic [47:0] IMG_ALL    = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] EXP_DIL    = {8'h00, 8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h00};
    localparam logic [47:0] EXP_ERO    = {8'h00, 8'h00, 8'h1C, 8'h1C, 8'h00, 8'h00};
    localparam logic [47:0] EXP_BORDER = {8'h00, 8'h7E, 8'h7E, 8'h7E, 8'h7E, 8'h00};
    localparam logic [47:0] EXP_ZERO   = 48'h0;
    // Only centres 0..38 leave the block within a frame.
    localparam logic [47:0] CMASK      = 48'h007F_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    logic mode;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   idle_bad = 0;
    int   diffs;

    bit q0[$], q1[$], cap[$], ref_q[$];
    int tin[$], tout0[$];

    vip_bit_morph_3x3_if per_if ();
    vip_bit_morph_3x3_if post0_if ();
    vip_bit_morph_3x3_if post1_if ();

    vip_bit_morph_3x3 #(.IMG_W(W), .IMG_H(H), .BORDER(0), .CW(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .per(per_if), .post(post0_if));

    vip_bit_morph_3x3 #(.IMG_W(W), .IMG_H(H), .BORDER(1), .CW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .per(per_if), .post(post1_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (per_if.frame_clken) tin.push_back(cyc);
        if (post0_if.frame_clken) begin
            q0.push_back(post0_if.img_bit);
            tout0.push_back(cyc);
        end
        if (post1_if.frame_clken) q1.push_back(post1_if.img_bit);
        if (!post0_if.frame_href && post0_if.img_bit !== 1'b0) idle_bad = idle_bad + 1;
        if (!post1_if.frame_href && post1_if.img_bit !== 1'b0) idle_bad = idle_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] img, input int gap, input int nlines,
                              input int tog_row, input int rst_row);
        q0.delete(); q1.delete(); tin.delete(); tout0.delete();
        tick();
        per_if.frame_vsync = 1'b1; per_if.frame_href = 1'b0;
        per_if.frame_clken = 1'b0; per_if.img_bit = 1'b0;
        repeat (3) tick();
        per_if.frame_vsync = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < nlines; r++) begin
            if (r == tog_row) mode = ~mode;
            for (int c = 0; c < W; c++) begin
                tick();
                per_if.frame_href = 1'b1; per_if.frame_clken = 1'b1;
                per_if.img_bit = img[r*W+c];
                if (r == rst_row && c == 4) begin
                    tick();
                    per_if.frame_clken = 1'b0;
                    checks++;
                    assert ({post0_if.frame_href, post0_if.img_bit} === 2'b11) else begin
                        errors++;
                        $error("FAIL pre_rst href/bit got %b want 11",
                               {post0_if.frame_href, post0_if.img_bit});
                    end
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    assert ({post0_if.frame_vsync, post0_if.frame_href, post0_if.frame_clken,
                             post0_if.img_bit} === 4'b0000) else begin
                        errors++;
                        $error("FAIL rst_async outputs got %b want 0000",
                               {post0_if.frame_vsync, post0_if.frame_href,
                                post0_if.frame_clken, post0_if.img_bit});
                    end
                    per_if.frame_href = 1'b0; per_if.img_bit = 1'b0;
                    tick(); tick();
                    rst_n = 1'b1;
                    repeat (3) tick();
                    return;
                end
                for (int g = 1; g < gap; g++) begin
                    tick();
                    per_if.frame_clken = 1'b0; per_if.img_bit = 1'b0;
                end
            end
            tick();
            per_if.frame_href = 1'b0; per_if.frame_clken = 1'b0; per_if.img_bit = 1'b0;
            tick(); tick();
        end
        repeat (6) tick();
    endtask

    task automatic check_frame(input string tag, input logic [47:0] exp, input int exp_ones);
        logic [47:0] got;
        logic        prime;
        int          ones;
        got = '0; prime = 1'b0; ones = 0;
        checks++;
        assert (cap.size() === N) else begin
            errors++;
            $error("FAIL %s_count got %0d want %0d", tag, cap.size(), N);
        end
        for (int k = 0; k < cap.size(); k++) begin
            if (k < W + 1) prime = prime | cap[k];
            else if (k - W - 1 < 48) begin
                got[k-W-1] = cap[k];
                ones += int'(cap[k]);
            end
        end
        checks++;
        assert (prime === 1'b0) else begin
            errors++;
            $error("FAIL %s_prime got %b want 0", tag, prime);
        end
        checks++;
        assert (got === (exp & CMASK)) else begin
            errors++;
            $error("FAIL %s_image got %h want %h", tag, got, exp & CMASK);
        end
        checks++;
        assert (ones === exp_ones) else begin
            errors++;
            $error("FAIL %s_ones got %0d want %0d", tag, ones, exp_ones);
        end
    endtask

    task automatic check_lag(input string tag);
        int bad;
        int n;
        bad = (tin.size() != tout0.size()) ? 1 : 0;
        n = (tin.size() < tout0.size()) ? tin.size() : tout0.size();
        for (int i = 0; i < n; i++) begin
            if (tout0[i] - tin[i] != 3) bad++;
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s_lag bad=%0d want 0 (in=%0d out=%0d)", tag, bad, tin.size(), tout0.size());
        end
    endtask

    initial begin
        rst_n = 1'b1; mode = 1'b0;
        per_if.frame_vsync = 1'b0; per_if.frame_href = 1'b0;
        per_if.frame_clken = 1'b0; per_if.img_bit = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        assert ({post0_if.frame_vsync, post0_if.frame_href, post0_if.frame_clken, post0_if.img_bit,
                 post1_if.frame_vsync, post1_if.frame_href, post1_if.frame_clken, post1_if.img_bit}
                === 8'h00) else begin
            errors++;
            $error("FAIL reset_outputs got %b%b%b%b want 0000", post0_if.frame_vsync,
                   post0_if.frame_href, post0_if.frame_clken, post0_if.img_bit);
        end
        rst_n = 1'b1;
        repeat (2) tick();

        // Dilation of a lone pixel, dense clken.
        mode = 1'b0;
        send_frame(IMG_LONE, 1, H, -1, -1);
        cap = q0; check_frame("dil_lone", EXP_DIL, 9); check_lag("dil_lone");
        ref_q = q0;
        cap = q1; check_frame("dil_lone_b1", EXP_DIL, 9);

        // Same frame with clken 1 of 3: identical pixel sequence.
        send_frame(IMG_LONE, 3, H, -1, -1);
        cap = q0; check_frame("gap_lone", EXP_DIL, 9); check_lag("gap_lone");
        diffs = (q0.size() != ref_q.size()) ? 1 : 0;
        for (int i = 0; i < q0.size() && i < ref_q.size(); i++)
            if (q0[i] !== ref_q[i]) diffs++;
        checks++;
        assert (diffs === 0) else begin
            errors++;
            $error("FAIL gap_same_seq diffs got %0d want 0", diffs);
        end

        // Erosion of a solid block, then of an all-ones frame.
        mode = 1'b1;
        send_frame(IMG_BLOCK, 1, H, -1, -1);
        cap = q0; check_frame("ero_block", EXP_ERO, 6);
        cap = q1; check_frame("ero_block_b1", EXP_ERO, 6);
        send_frame(IMG_ALL, 1, H, -1, -1);
        cap = q0; check_frame("ero_all", IMG_ALL, 39);
        cap = q1; check_frame("ero_all_b1", EXP_BORDER, 24);

        // Dilation of all-ones: border instance keeps only the interior.
        mode = 1'b0;
        send_frame(IMG_ALL, 1, H, -1, -1);
        cap = q0; check_frame("dil_all", IMG_ALL, 39);
        cap = q1; check_frame("dil_all_b1", EXP_BORDER, 24);

        // Mode flipped mid-frame: this frame stays dilation, next is erosion.
        mode = 1'b0;
        send_frame(IMG_LONE, 1, H, 3, -1);
        cap = q0; check_frame("mode_hold", EXP_DIL, 9);
        send_frame(IMG_BLOCK, 1, H, -1, -1);
        cap = q0; check_frame("mode_next", EXP_ERO, 6);
        send_frame(IMG_LONE, 1, H, -1, -1);
        cap = q0; check_frame("ero_lone", EXP_ZERO, 0);

        // Short all-ones frame, then a full frame must be unaffected.
        mode = 1'b0;
        send_frame(IMG_ALL, 1, 3, -1, -1);
        send_frame(IMG_LONE, 1, H, -1, -1);
        cap = q0; check_frame("after_short", EXP_DIL, 9);

        // Reset mid-line during an erosion frame, then a clean dilation frame.
        mode = 1'b1;
        send_frame(IMG_ALL, 1, H, -1, 2);
        mode = 1'b0;
        send_frame(IMG_LONE, 1, H, -1, -1);
        cap = q0; check_frame("after_rst", EXP_DIL, 9); check_lag("after_rst");
        cap = q1; check_frame("after_rst_b1", EXP_DIL, 9);

        checks++;
        assert (idle_bad === 0) else begin
            errors++;
            $error("FAIL idle_bit nonzero samples got %0d want 0", idle_bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vip_bit_morph_3x3.md
# vip_bit_morph_3x3

Parametrised 3x3 binary morphology filter for the Sobel/edge video path. It accepts a 1-bit pixel stream framed by vsync, href and clken. It produces a dilated or eroded 1-bit stream with the same framing, delayed by a fixed clock latency. Frame geometry, border suppression width and operation mode are configurable. Frame counters resynchronise on every vsync, so the block replaces hard-coded single-purpose dilation/erosion detectors.

## Interface
- IMG_W, 640: active pixels per line (clken pulses per href-high line).
- IMG_H, 480: active lines per frame.
- BORDER, 1: output forced to 0 within BORDER pixels of any frame edge (0 = no suppression).
- CW, 12: width of column/row counters. Must satisfy 2^CW > max(IMG_W, IMG_H).
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = dilation (OR of window), 1 = erosion (AND of window).
- per_frame_vsync  in  1  frame sync, high between frames.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel valid strobe.
- per_img_bit  in  1  input pixel, 1 = white.
- post_frame_vsync  out  1  vsync delayed by LAT.
- post_frame_href  out  1  href delayed by LAT.
- post_frame_clken  out  1  clken delayed by LAT.
- post_img_bit  out  1  morphology result. 0 whenever post_frame_href = 0.

## Operation
- Window: the sub-module holds two line buffers of IMG_W bits and 3x3 window registers. These advance only on per_frame_clken. Output pixel k corresponds to the window centred on input pixel k-IMG_W-1 in the stream.
- Out-of-frame neighbours (row 0, row IMG_H-1, column 0, column IMG_W-1) are padded with 0 in dilation and 1 in erosion, so edges do not shrink or grow artificially.
- Reduction is two registered stages:
  - stage 1: per-row OR/AND of 3 bits;
  - stage 2: OR/AND of the 3 row results.
- Mode latch: mode is sampled into mode_q on the rising edge of per_frame_vsync. mode_q is constant for the whole frame, and a mid-frame change of mode has no effect until the next frame.
- Counters:
  - col_cnt/row_cnt track the centre pixel. Both clear on rising vsync.
  - col_cnt increments on each window advance and wraps at IMG_W-1, incrementing row_cnt.
  - row_cnt saturates at IMG_H-1 until the next vsync, with no wrap into a false second frame.
- Border: the output is 0 when col < BORDER, col ≥ IMG_W-BORDER, row < BORDER or row ≥ IMG_H-BORDER.
- Reset state: all outputs 0; line buffers undefined but masked by padding; mode_q = 0; counters 0.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). The block resumes cleanly on the next rising vsync.
- Short frame (vsync before IMG_H lines): counters clear and no stale window data is emitted. Padding masks the first line of the new frame.

## Timing
- LAT = 3 clk for vsync/href/clken: window register, stage 1, stage 2. The control delay line is ungated, clocked every clk.
- post_img_bit is valid in the cycle post_frame_clken = 1. Between clken pulses it holds its last value while href = 1.
- clken may be gapped (any duty cycle). The result must be independent of gap pattern.
- Stage registers load only when their clken-delayed enable is high.

## Structure
- Package vip_morph_pkg holds:
  - MODE_DILATE = 1'b0, MODE_ERODE = 1'b1;
  - pad-value function pad_bit(mode);
  - LAT = 3.
- Sub-module vip_bit_window_3x3 contains the line buffers, window registers and col/row counters. It outputs p11..p33, the centre coordinates and a window-valid strobe.
- The top level contains the mode latch, reduction stages, border mask and control delay line.

## Test plan
- Configuration for all scenarios: IMG_W = 8, IMG_H = 6, BORDER = 0.
- Dilation single pixel: mode = 0, a lone 1 at (3,2) → output has 1 exactly at the 3x3 block cols 2-4, rows 1-3 and 0 elsewhere; 9 ones total.
- Erosion of a solid block: mode = 1, ones at cols 1-5, rows 1-4 → output ones at cols 2-4, rows 2-3 only. An all-ones frame → all-ones output, since padding is 1.
- Border: BORDER = 1, all-ones frame, mode = 0 → output 1 only at cols 1-6, rows 1-4; 24 ones.
- Gapped clken: repeat the dilation scenario with clken high 1 of 3 cycles → identical pixel sequence; post_* lags input by exactly 3 clk.
- Mode change and reset: toggle mode mid-frame → the current frame is unchanged and the next frame uses the new mode. Assert rst_n low mid-line → all outputs 0 in the same cycle, and a correct frame follows the next vsync.
